// File: rtl/mux_sel_pipe.sv
// mux_sel_pipe: N-channel registered selector; direct select by sel, or round-robin scan when built with MUX_SEL_PIPE_SCAN_EN.
// Latency: 1 cycle from input handshake to out_valid; one beat per cycle at full throughput.
// Backpressure: in_ready is combinational and all-zero while the output beat is stalled (out_valid && !out_ready).
module mux_sel_pipe #(
   parameter int WIDTH  = 16,
   parameter int NUM_CH = 9,
   parameter int SEL_W  = 4
) (
   input  logic                    clk,
   input  logic                    resetn,
   input  logic [NUM_CH*WIDTH-1:0] in_data,
   input  logic [NUM_CH-1:0]       in_valid,
   output logic [NUM_CH-1:0]       in_ready,
   input  logic [SEL_W-1:0]        sel,
   input  logic                    mode,
   output logic [WIDTH-1:0]        dout,
   output logic [SEL_W-1:0]        out_ch,
   output logic                    out_err,
   output logic                    out_valid,
   input  logic                    out_ready
);

   localparam logic [SEL_W:0]   NUM_CH_W = (SEL_W+1)'(NUM_CH);
   localparam logic [SEL_W-1:0] LAST_CH  = SEL_W'(NUM_CH - 1);

   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] dout_q, dout_d;
   logic [SEL_W-1:0] out_ch_q, out_ch_d;
   logic             out_err_q, out_err_d;

   logic             load;       // output register may take a new beat this cycle
   logic             grant_vld;  // a real channel is selected and offers data
   logic             fill;       // direct mode with out-of-range sel
   logic [SEL_W-1:0] grant_ch;
   logic [WIDTH-1:0] grant_dat;
   logic             scan_sel;   // round-robin pointer chooses the channel
   logic             scan_hit;
   logic [SEL_W-1:0] scan_ch;

   assign load = !out_valid_q || out_ready;

`ifdef MUX_SEL_PIPE_SCAN_EN
   logic [SEL_W-1:0]  ptr_q, ptr_d;
   logic [NUM_CH-1:0] scan_rot;  // in_valid rotated so bit 0 is the channel at ptr
   logic [SEL_W:0]    scan_sum;

   assign scan_sel = mode;
   assign scan_rot = NUM_CH'({in_valid, in_valid} >> ptr_q);

   // Find the first valid channel at or after ptr, wrapping modulo NUM_CH
   always_comb begin
      scan_hit = 1'b0;
      scan_ch  = '0;
      scan_sum = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (!scan_hit && scan_rot[i]) begin
            scan_hit = 1'b1;
            scan_sum = {1'b0, ptr_q} + (SEL_W+1)'(i);
            if (scan_sum >= NUM_CH_W) begin
               scan_sum = scan_sum - NUM_CH_W;
            end
            scan_ch = scan_sum[SEL_W-1:0];
         end
      end
   end

   // Pointer moves past the winner only when a scan beat is actually captured
   always_comb begin
      ptr_d = ptr_q;
      if (scan_sel && load && scan_hit) begin
         ptr_d = (scan_ch == LAST_CH) ? '0 : scan_ch + SEL_W'(1);
      end
   end

   // Pointer register; survives direct-mode periods, cleared only by reset
   always_ff @(posedge clk) begin
      if (!resetn) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end
`else
   logic unused_mode;

   assign unused_mode = mode;
   assign scan_sel    = 1'b0;
   assign scan_hit    = 1'b0;
   assign scan_ch     = '0;
`endif

   // Decide which channel (or the fill word) is offered to the output register
   always_comb begin
      grant_vld = 1'b0;
      fill      = 1'b0;
      grant_ch  = sel;
      if (scan_sel) begin
         grant_vld = scan_hit;
         grant_ch  = scan_ch;
      end else if ({1'b0, sel} < NUM_CH_W) begin
         for (int k = 0; k < NUM_CH; k++) begin
            if (SEL_W'(k) == sel) begin
               grant_vld = in_valid[k];
            end
         end
      end else begin
         fill = 1'b1;
      end
   end

   // Data of the granted channel; only ever feeds a register
   always_comb begin
      grant_dat = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         if (SEL_W'(k) == grant_ch) begin
            grant_dat = in_data[k*WIDTH +: WIDTH];
         end
      end
   end

   // One-hot accept to the granted channel; fill beats never accept input
   always_comb begin
      in_ready = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         in_ready[k] = resetn && load && grant_vld && (SEL_W'(k) == grant_ch);
      end
   end

   // Output next state: capture on load, drop the beat when nothing to load, else hold
   always_comb begin
      out_valid_d = out_valid_q;
      dout_d      = dout_q;
      out_ch_d    = out_ch_q;
      out_err_d   = out_err_q;
      if (load) begin
         out_valid_d = grant_vld || fill;
         if (grant_vld || fill) begin
            dout_d    = fill ? {WIDTH{1'b1}} : grant_dat;
            out_ch_d  = grant_ch;
            out_err_d = fill;
         end
      end
   end

   // Output register with synchronous reset discarding any pending beat
   always_ff @(posedge clk) begin
      if (!resetn) begin
         out_valid_q <= 1'b0;
         dout_q      <= '0;
         out_ch_q    <= '0;
         out_err_q   <= 1'b0;
      end else begin
         out_valid_q <= out_valid_d;
         dout_q      <= dout_d;
         out_ch_q    <= out_ch_d;
         out_err_q   <= out_err_d;
      end
   end

   assign out_valid = out_valid_q;
   assign dout      = dout_q;
   assign out_ch    = out_ch_q;
   assign out_err   = out_err_q;

endmodule

// File: tb/tb_mux_sel_pipe.sv
// Directed bench for mux_sel_pipe at default parameters, plus a seeded random run against a reference model.
// Inputs change and outputs are sampled on the falling edge; the DUT acts on the rising edge.
// Scan-mode expectations follow whether MUX_SEL_PIPE_SCAN_EN is defined for the build.
module tb_mux_sel_pipe;
   localparam int WIDTH  = 16;
   localparam int NUM_CH = 9;
   localparam int SEL_W  = 4;

   logic                    clk = 1'b0;
   logic                    resetn;
   logic [NUM_CH*WIDTH-1:0] in_data;
   logic [NUM_CH-1:0]       in_valid;
   logic [NUM_CH-1:0]       in_ready;
   logic [SEL_W-1:0]        sel;
   logic                    mode;
   logic [WIDTH-1:0]        dout;
   logic [SEL_W-1:0]        out_ch;
   logic                    out_err;
   logic                    out_valid;
   logic                    out_ready;

   int errors = 0;
   int checks = 0;

   logic [WIDTH-1:0] chan [NUM_CH];

   // reference model state
   logic             m_vld;
   logic [WIDTH-1:0] m_dat;
   int               m_ch;
   logic             m_err;
   int               m_ptr;
   logic [NUM_CH-1:0] m_rdy;
   int               hs_model;
   int               hs_dut;

   always #5 clk = ~clk;

   mux_sel_pipe #(.WIDTH(WIDTH), .NUM_CH(NUM_CH), .SEL_W(SEL_W)) dut (
      .clk       (clk),
      .resetn    (resetn),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .sel       (sel),
      .mode      (mode),
      .dout      (dout),
      .out_ch    (out_ch),
      .out_err   (out_err),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_out(input string tag, input logic v, input logic [WIDTH-1:0] d,
                          input int ch, input logic e);
      chk({tag, ".out_valid"}, 32'(out_valid), 32'(v));
      chk({tag, ".dout"},      32'(dout),      32'(d));
      chk({tag, ".out_ch"},    32'(out_ch),    32'(ch));
      chk({tag, ".out_err"},   32'(out_err),   32'(e));
   endtask

   task automatic pack();
      for (int k = 0; k < NUM_CH; k++) in_data[k*WIDTH +: WIDTH] = chan[k];
   endtask

   task automatic cyc();
      @(posedge clk);
      @(negedge clk);
   endtask

   function automatic logic [NUM_CH-1:0] onehot(input int s);
      logic [NUM_CH-1:0] one;
      one = 1;
      return one << s;
   endfunction

   initial begin
      int sweep [7];
      logic [WIDTH-1:0] base [NUM_CH];
      logic scan_on, ld, found;
      int win, s;

      sweep = '{0, 1, 2, 3, 4, 7, 8};
      base  = '{16'h000a, 16'h000b, 16'h000c, 16'h000d, 16'h000e,
                16'h000f, 16'h0011, 16'h0012, 16'h0013};
      for (int k = 0; k < NUM_CH; k++) chan[k] = base[k];
      pack();
      resetn    = 1'b0;
      in_valid  = '1;
      sel       = '0;
      mode      = 1'b0;
      out_ready = 1'b1;

      // reset held for two edges with every channel valid
      cyc();
      chk_out("rst1", 1'b0, 16'h0000, 0, 1'b0);
      chk("rst1.in_ready", 32'(in_ready), 32'h0);
      cyc();
      chk_out("rst2", 1'b0, 16'h0000, 0, 1'b0);
      chk("rst2.in_ready", 32'(in_ready), 32'h0);

      // first handshake after release, beat visible one cycle later
      resetn = 1'b1;
      #1;
      chk("rel.in_ready", 32'(in_ready), 32'(onehot(0)));
      chk("rel.out_valid", 32'(out_valid), 32'h0);
      cyc();
      chk_out("rel.beat", 1'b1, 16'h000a, 0, 1'b0);

      // direct sweep at full throughput
      foreach (sweep[i]) begin
         sel = SEL_W'(sweep[i]);
         #1;
         chk($sformatf("sweep%0d.in_ready", sweep[i]), 32'(in_ready), 32'(onehot(sweep[i])));
         cyc();
         chk_out($sformatf("sweep%0d", sweep[i]), 1'b1, base[sweep[i]], sweep[i], 1'b0);
      end

      // out-of-range selects produce flagged fill beats and accept nothing
      for (int s2 = 9; s2 <= 15; s2++) begin
         sel = SEL_W'(s2);
         #1;
         chk($sformatf("oor%0d.in_ready", s2), 32'(in_ready), 32'h0);
         cyc();
         chk_out($sformatf("oor%0d", s2), 1'b1, 16'hffff, s2, 1'b0 | 1'b1);
      end

      // back-pressure: beat from channel 2 holds while sel moves to 3
      sel = 4'd2;
      #1;
      chk("bp.load.in_ready", 32'(in_ready), 32'(onehot(2)));
      cyc();
      chk_out("bp.load", 1'b1, 16'h000c, 2, 1'b0);
      out_ready = 1'b0;
      sel       = 4'd3;
      for (int n = 0; n < 3; n++) begin
         #1;
         chk($sformatf("bp.stall%0d.in_ready", n), 32'(in_ready), 32'h0);
         cyc();
         chk_out($sformatf("bp.stall%0d", n), 1'b1, 16'h000c, 2, 1'b0);
      end
      out_ready = 1'b1;
      #1;
      chk("bp.release.in_ready", 32'(in_ready), 32'(onehot(3)));
      cyc();
      chk_out("bp.release", 1'b1, 16'h000d, 3, 1'b0);

      // selected channel not valid: beat drains and nothing is accepted
      in_valid = 9'h1ef;
      sel      = 4'd4;
      #1;
      chk("novld.in_ready", 32'(in_ready), 32'h0);
      cyc();
      chk("novld.out_valid", 32'(out_valid), 32'h0);
      in_valid = '1;

      // reset during a stall discards the held beat
      sel = 4'd1;
      cyc();
      chk_out("midrst.load", 1'b1, 16'h000b, 1, 1'b0);
      out_ready = 1'b0;
      cyc();
      resetn = 1'b0;
      #1;
      chk("midrst.in_ready", 32'(in_ready), 32'h0);
      cyc();
      chk_out("midrst", 1'b0, 16'h0000, 0, 1'b0);
      resetn    = 1'b1;
      out_ready = 1'b1;

`ifdef MUX_SEL_PIPE_SCAN_EN
      // round-robin over channels 2,5,8 with sel ignored, then drop channel 5
      mode     = 1'b1;
      sel      = 4'd15;
      in_valid = 9'b1_0010_0100;
      begin
         int seq [10];
         seq = '{2, 5, 8, 2, 5, 8, 2, 8, 2, 8};
         for (int n = 0; n < 10; n++) begin
            if (n == 5) in_valid = 9'b1_0000_0100;
            #1;
            chk($sformatf("scan%0d.in_ready", n), 32'(in_ready), 32'(onehot(seq[n])));
            cyc();
            chk_out($sformatf("scan%0d", n), 1'b1, base[seq[n]], seq[n], 1'b0);
         end
      end
`else
      // without scan support the mode input has no effect
      mode = 1'b1;
      sel  = 4'd3;
      #1;
      chk("nomode.in_ready", 32'(in_ready), 32'(onehot(3)));
      cyc();
      chk_out("nomode", 1'b1, 16'h000d, 3, 1'b0);
      sel = 4'd12;
      cyc();
      chk_out("nomode.oor", 1'b1, 16'hffff, 12, 1'b1);
`endif

      // random run against the reference model, starting from reset
      resetn = 1'b0;
      cyc();
      resetn   = 1'b1;
      m_vld    = 1'b0;
      m_dat    = '0;
      m_ch     = 0;
      m_err    = 1'b0;
      m_ptr    = 0;
      hs_model = 0;
      hs_dut   = 0;
      for (int n = 0; n < 200; n++) begin
         for (int k = 0; k < NUM_CH; k++) chan[k] = WIDTH'($urandom);
         pack();
         in_valid  = NUM_CH'($urandom);
         sel       = SEL_W'($urandom);
         mode      = 1'($urandom);
         out_ready = ($urandom_range(0, 3) != 0);
`ifdef MUX_SEL_PIPE_SCAN_EN
         scan_on = mode;
`else
         scan_on = 1'b0;
`endif
         ld    = !m_vld || out_ready;
         m_rdy = '0;
         found = 1'b0;
         win   = 0;
         if (scan_on) begin
            for (int i = 0; i < NUM_CH; i++) begin
               if (!found && in_valid[(m_ptr + i) % NUM_CH]) begin
                  found = 1'b1;
                  win   = (m_ptr + i) % NUM_CH;
               end
            end
         end
         s = int'(sel);
         if (ld) begin
            if (scan_on) begin
               m_vld = found;
               if (found) begin
                  m_rdy[win] = 1'b1;
                  m_dat = chan[win];
                  m_ch  = win;
                  m_err = 1'b0;
                  m_ptr = (win + 1) % NUM_CH;
               end
            end else if (s < NUM_CH) begin
               m_vld = in_valid[s];
               if (in_valid[s]) begin
                  m_rdy[s] = 1'b1;
                  m_dat = chan[s];
                  m_ch  = s;
                  m_err = 1'b0;
               end
            end else begin
               m_vld = 1'b1;
               m_dat = '1;
               m_ch  = s;
               m_err = 1'b1;
            end
         end
         if (m_rdy != 0) hs_model++;
         #1;
         if ((in_ready & in_valid) != 0) hs_dut++;
         chk($sformatf("rnd%0d.in_ready", n), 32'(in_ready), 32'(m_rdy));
         cyc();
         chk_out($sformatf("rnd%0d", n), m_vld, m_dat, m_ch, m_err);
      end
      chk("rnd.handshakes", 32'(hs_dut), 32'(hs_model));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mux_sel_pipe.md
# mux_sel_pipe

Parametrised N-channel, W-bit registered selector with per-channel valid/ready inputs and a single valid/ready output. Generalises the team's fixed 9-to-1 combinational 16-bit mux into a pipelined stage for datapath channel merging. It has two modes: direct select, where the `sel` port picks the channel, and round-robin scan, where an internal pointer picks the next ready channel. Out-of-range selects produce the all-ones fill word, matching the existing mux family.

## Interface
- `WIDTH`, 16, data width per channel
- `NUM_CH`, 9, number of input channels (2..2**SEL_W)
- `SEL_W`, 4, width of `sel` / `out_ch`
- `clk`  in  1  clock; all logic on rising edge
- `resetn`  in  1  reset; one clock; reset is synchronous and active-low
- `in_data`  in  NUM_CH*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH]
- `in_valid`  in  NUM_CH  per-channel data valid
- `in_ready`  out  NUM_CH  per-channel accept, one-hot or zero
- `sel`  in  SEL_W  direct-mode channel select
- `mode`  in  1  0 = direct, 1 = round-robin scan
- `dout`  out  WIDTH  registered output data
- `out_ch`  out  SEL_W  channel index of the beat in `dout`
- `out_err`  out  1  beat is fill caused by out-of-range `sel`
- `out_valid`  out  1  output beat valid
- `out_ready`  in  1  downstream accept

## Operation
- `load = !out_valid || out_ready`. All loads and in_ready depend on it; when `load` = 0, every `in_ready` is 0 and the outputs hold.
- **Direct mode, `sel` < NUM_CH:**
  - If `load && in_valid[sel]`: `in_ready[sel]`=1; next cycle `dout`=channel data, `out_ch`=`sel`, `out_err`=0, `out_valid`=1.
  - If `in_valid[sel]`=0: no load; `out_valid` clears if `out_ready`.
- **Direct mode, `sel` >= NUM_CH:**
  - If `load`: next cycle `dout`={WIDTH{1'b1}}, `out_ch`=`sel`, `out_err`=1, `out_valid`=1; all `in_ready`=0.
  - One fill beat per accepting cycle for as long as `sel` stays out of range.
- **Scan mode:**
  - Pointer `ptr` (0..NUM_CH-1). The winner is the first k with `in_valid[k]`=1, searching `ptr`, `ptr`+1, … with modulo NUM_CH wrap.
  - If `load` and a winner exists: `in_ready[winner]`=1, capture as in direct mode (`out_err`=0), and `ptr` becomes winner+1 (NUM_CH-1 wraps to 0).
  - If no winner: no load and `ptr` unchanged. `sel` is ignored.
- **Mode switching:** `mode` is sampled every cycle and may change at any cycle, including while `out_valid`=1 and stalled. The held beat is unaffected. `ptr` is retained across direct-mode periods.
- **Reset (`resetn`=0 at a clock edge, including mid-stall):** `out_valid`=0, `dout`=0, `out_ch`=0, `out_err`=0, `ptr`=0. `in_ready` is 0 while `resetn`=0, and any pending beat is discarded.

## Timing
- Latency is 1 cycle from the input handshake (`in_valid[k] && in_ready[k]` at edge n) to `out_valid`=1 after edge n.
- Full throughput: one beat per cycle when `out_ready`=1 continuously.
- `in_ready` is combinational from `in_valid`, `sel`, `mode`, `ptr`, `out_valid` and `out_ready`. There is no combinational path from `in_data` to any output.
- A stall (`out_valid`=1, `out_ready`=0) holds `dout`, `out_ch` and `out_err` stable until accepted.
- Simultaneous accept-and-load: the new beat replaces the old one at the same edge with no bubble.

## Configuration
- `MUX_SEL_PIPE_SCAN_EN` defined:
  - scan mode and `ptr` are present, as described above.
- Not defined:
  - the `mode` port exists but is ignored;
  - the block always operates in direct mode;
  - no `ptr` register is built.

## Test plan
Defaults (WIDTH=16, NUM_CH=9); channels 0..8 hold 0x000a, 0x000b, 0x000c, 0x000d, 0x000e, 0x000f, 0x0011, 0x0012, 0x0013.
- **Reset:** hold `resetn`=0 for 2 cycles with all `in_valid`=1 -> `out_valid`=0, `dout`=0, `in_ready`=0; after release, `out_valid` rises 1 cycle after the first handshake.
- **Direct sweep:** all valid, `out_ready`=1, `sel`=0,1,2,3,4,7,8 -> `dout`=000a,000b,000c,000d,000e,0012,0013, each 1 cycle later, with `out_ch` equal to `sel` and `out_err`=0.
- **Out-of-range:** `sel`=9..15, `out_ready`=1 -> `dout`=ffff, `out_err`=1, `out_ch`=`sel`, and all `in_ready` stay 0.
- **Back-pressure:** `sel`=2, `out_ready`=0 for 3 cycles -> `dout` held at 000c, `in_ready`=0; when `out_ready` rises, the next beat loads with no bubble.
- **Scan:** `mode`=1, `in_valid`=9'b1_0010_0100, `out_ready`=1 -> `out_ch` sequence 2,5,8,2,…; dropping `in_valid[5]` mid-run gives a 2,8 alternation.
- **Random:** 200 cycles of random data, valid, sel, mode and out_ready -> matches the scoreboard model, with no lost or duplicated input handshakes.
